// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide engine that owns the MIPS HI/LO register pair.
// Build option: define HILO_MULDIV_DIV_EN to include the divider (divu/div).
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   acc_q, acc_d, mq_q, mq_d, b_q;
    logic               neg_q;
    logic [WIDTH-1:0]   hi_q, lo_q, res_hi, res_lo;
    logic               done_q, dbz_q;
    logic               sgn_a, sgn_b, launch;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;
`ifdef HILO_MULDIV_DIV_EN
    logic               is_div_q, sa_q, dbz_pend_q, div_ge;
    logic [WIDTH-1:0]   a_raw_q;
    logic [WIDTH:0]     shifted;
`endif

    assign sgn_a = op[0] & a[WIDTH-1];
    assign sgn_b = op[0] & b[WIDTH-1];
    assign abs_a = sgn_a ? -a : a;
    assign abs_b = sgn_b ? -b : b;

`ifdef HILO_MULDIV_DIV_EN
    assign launch = (state_q == S_IDLE) && start;
`else
    // Without the divider, divide ops complete immediately as no-ops.
    assign launch = (state_q == S_IDLE) && start && !op[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (launch) state_d = S_RUN;
            S_RUN:   if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        if (state_q == S_RUN || state_q == S_FIX) busy = 1'b1;
    end

    // One iteration: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        acc_d   = mul_sum[WIDTH:1];
        mq_d    = {mul_sum[0], mq_q[WIDTH-1:1]};
`ifdef HILO_MULDIV_DIV_EN
        shifted = {acc_q, mq_q[WIDTH-1]};
        div_ge  = shifted >= {1'b0, b_q};
        if (is_div_q) begin
            acc_d = div_ge ? (shifted[WIDTH-1:0] - b_q) : shifted[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], div_ge};
        end
`endif
    end

    always_comb begin
        prod   = {acc_q, mq_q};
        if (neg_q) prod = -prod;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
`ifdef HILO_MULDIV_DIV_EN
        if (is_div_q) begin
            if (dbz_pend_q) begin
                res_hi = a_raw_q;
                res_lo = '1;
            end else begin
                // MIN / -1 falls out naturally: |MIN| stays MIN and neg is clear.
                res_lo = neg_q ? -mq_q : mq_q;
                res_hi = sa_q ? -acc_q : acc_q;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            mq_q       <= '0;
            b_q        <= '0;
            neg_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
`ifdef HILO_MULDIV_DIV_EN
            is_div_q   <= 1'b0;
            sa_q       <= 1'b0;
            dbz_pend_q <= 1'b0;
            a_raw_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (we_hi) hi_q <= wd;
                    if (we_lo) lo_q <= wd;
                    if (launch) begin
                        cnt_q      <= CNT_W'(WIDTH);
                        acc_q      <= '0;
                        mq_q       <= abs_a;
                        b_q        <= abs_b;
                        neg_q      <= sgn_a ^ sgn_b;
`ifdef HILO_MULDIV_DIV_EN
                        is_div_q   <= op[1];
                        sa_q       <= sgn_a;
                        dbz_pend_q <= op[1] && (b == '0);
                        a_raw_q    <= a;
`endif
                    end
`ifndef HILO_MULDIV_DIV_EN
                    if (start && op[1]) done_q <= 1'b1;
`endif
                end
                S_RUN: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    acc_q <= acc_d;
                    mq_q  <= mq_d;
                end
                S_FIX: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
`ifdef HILO_MULDIV_DIV_EN
                    dbz_q  <= dbz_pend_q;
`endif
                end
                default: ;
            endcase
        end
    end

    assign done = done_q;
    assign dbz  = dbz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule
